// File: rtl/fifo144_reader_if.sv
// FIFO read port plus 72-bit output stream of fifo144_reader.
// master is the reader; slave is the FIFO / downstream side.
interface fifo144_reader_if;
    logic         fifo_empty;
    logic         fifo_rden;
    logic [143:0] fifo_dout;
    logic [71:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [3:0]   buf_level;

    modport master (
        input  fifo_empty, fifo_dout, out_ready,
        output fifo_rden, out_data, out_valid, out_last, buf_level
    );

    modport slave (
        output fifo_empty, fifo_dout, out_ready,
        input  fifo_rden, out_data, out_valid, out_last, buf_level
    );
endinterface

// File: rtl/fifo144_reader.sv
// Drains a non-FWFT 144-bit FIFO into a small ring buffer and emits each
// word as two 72-bit beats (lower half first) on a valid/ready stream.
module fifo144_reader #(
    parameter int RD_LATENCY = 2,
    parameter int BUF_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    fifo144_reader_if.master bus
);
    localparam int         PTR_W   = $clog2(BUF_DEPTH);
    localparam logic [3:0] DEPTH_L = 4'(BUF_DEPTH);

    logic [RD_LATENCY-1:0] stage_q, stage_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [3:0]            level_q, level_d;
    logic                  half_q, half_d;
    logic [143:0]          mem_q [BUF_DEPTH];

    logic [3:0]   inflight;
    logic         rden;
    logic         capture;
    logic         out_valid;
    logic         xfer;
    logic         pop;
    logic [143:0] head;

    always_comb begin
        inflight = '0;
        for (int k = 0; k < RD_LATENCY; k++) begin
            inflight = inflight + 4'(stage_q[k]);
        end
    end

    // Credit covers both buffered and in-flight words, so a capture always finds room.
    assign rden      = !rst && !bus.fifo_empty && ((level_q + inflight) < DEPTH_L);
    assign capture   = stage_q[RD_LATENCY-1];
    assign out_valid = (level_q != 4'd0);
    assign xfer      = out_valid && bus.out_ready;
    assign pop       = xfer && half_q;
    assign head      = mem_q[rd_ptr_q];

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        stage_d  = RD_LATENCY'({stage_q, rden});
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        half_d   = half_q;
        if (capture) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (xfer) begin
            half_d = !half_q;
        end
        case ({capture, pop})
            2'b10:   level_d = level_q + 4'd1;
            2'b01:   level_d = level_q - 4'd1;
            default: level_d = level_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            half_q   <= 1'b0;
        end else begin
            stage_q  <= stage_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            half_q   <= half_d;
        end
    end

    // NOTE: the entry RAM is not reset; buf_level gates every read of it.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem_q[wr_ptr_q] <= bus.fifo_dout;
        end
    end

    always_comb begin
        bus.fifo_rden = rden;
        bus.out_valid = out_valid;
        bus.out_last  = out_valid && half_q;
        bus.buf_level = level_q;
        bus.out_data  = '0;
        if (out_valid) begin
            bus.out_data = half_q ? head[143:72] : head[71:0];
        end
    end

    // A capture into a full buffer would overwrite the unread head entry.
    assert property (@(posedge clk) disable iff (rst) !(capture && (level_q == DEPTH_L)));

endmodule
